// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio PWM output path.
//   SAMPLE_W  - width of the mixed sample word from the RAM controller
//   VOL_W     - width of the volume (right-shift) control
//   ST_*      - 2-bit encodings of the amplifier sequencing states
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int VOL_W    = 4;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WARM = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    typedef enum logic [1:0] {
        OFF  = ST_OFF,
        WARM = ST_WARM,
        RUN  = ST_RUN,
        STOP = ST_STOP
    } audio_state_e;

endpackage

// File: rtl/pwm_duty_conv.sv
// pwm_duty_conv: combinational sample-to-duty conversion.
// The sample is attenuated by a logical right shift of `volume` bits and
// the top PWM_BITS bits become the duty. With AUDIO_PWM_NOISE_SHAPE_EN the
// truncated residue from the previous conversion is added back first
// (first-order error feedback); overflow of that sum saturates the duty.
// Ports:
//   sample  in  SAMPLE_W   mixed sample to convert
//   volume  in  VOL_W      attenuation shift
//   err_in  in  residue    (noise shaping only) previous truncation error
//   err_out out residue    (noise shaping only) new truncation error
//   duty    out PWM_BITS   resulting PWM duty
module pwm_duty_conv
    import audio_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic [SAMPLE_W-1:0]          sample,
    input  logic [VOL_W-1:0]             volume,
`ifdef AUDIO_PWM_NOISE_SHAPE_EN
    input  logic [SAMPLE_W-PWM_BITS-1:0] err_in,
    output logic [SAMPLE_W-PWM_BITS-1:0] err_out,
`endif
    output logic [PWM_BITS-1:0]          duty
);

    localparam int ERR_W = SAMPLE_W - PWM_BITS;

    logic [SAMPLE_W-1:0] shifted_s;
`ifdef AUDIO_PWM_NOISE_SHAPE_EN
    logic [SAMPLE_W:0]   sum_s;
`else
    logic [ERR_W-1:0]    unused_low_s;
`endif

    // Attenuate, optionally fold in the residue, and keep the top bits.
    always_comb begin
        shifted_s = sample >> volume;
`ifdef AUDIO_PWM_NOISE_SHAPE_EN
        sum_s = {1'b0, shifted_s} + {{(PWM_BITS + 1){1'b0}}, err_in};
        if (sum_s[SAMPLE_W]) begin
            duty = {PWM_BITS{1'b1}};
        end else begin
            duty = sum_s[SAMPLE_W-1 -: PWM_BITS];
        end
        err_out = sum_s[ERR_W-1:0];
`else
        duty         = shifted_s[SAMPLE_W-1 -: PWM_BITS];
        unused_low_s = shifted_s[ERR_W-1:0];
`endif
    end

endmodule

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: PWM audio output stage with pop-free amplifier sequencing.
// Captures mixed samples on a strobe into a one-deep pending buffer, converts
// them to a PWM duty at each period boundary and drives the audio pin and the
// amplifier enable. Power-up plays WARMUP_PERIODS silent periods first;
// power-down finishes the current period before switching the amp off.
// Optional build macro: AUDIO_PWM_NOISE_SHAPE_EN (first-order error feedback).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            playback enable
//   sample_in     unsigned mixed sample, valid while sample_valid is high
//   sample_valid  one-cycle capture strobe
//   volume        attenuation as a right shift (0 = full scale)
//   pwm_out       PWM audio pin
//   aud_sd        amplifier enable (1 = on)
//   busy          high whenever the sequencer is not OFF
//   overrun_cnt   saturating count of samples overwritten before use
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int PWM_BITS       = 8,
    parameter int WARMUP_PERIODS = 16,
    parameter int OVR_BITS       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [VOL_W-1:0]    volume,
    output logic                pwm_out,
    output logic                aud_sd,
    output logic                busy,
    output logic [OVR_BITS-1:0] overrun_cnt
);

    localparam int WARM_W = (WARMUP_PERIODS > 1) ? $clog2(WARMUP_PERIODS) : 1;
    localparam logic [WARM_W-1:0]   WARM_LAST = WARM_W'(WARMUP_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX   = {PWM_BITS{1'b1}};
    localparam logic [OVR_BITS-1:0] OVR_MAX   = {OVR_BITS{1'b1}};

    audio_state_e        state_r;
    logic [PWM_BITS-1:0] cnt_r;
    logic [WARM_W-1:0]   warm_cnt_r;
    logic [PWM_BITS-1:0] duty_r;
    logic                pwm_r;
    logic                aud_sd_r;
    logic                busy_r;
    logic [SAMPLE_W-1:0] pend_r;
    logic                pend_valid_r;
    logic [OVR_BITS-1:0] ovr_r;
    logic [PWM_BITS-1:0] conv_duty_s;
`ifdef AUDIO_PWM_NOISE_SHAPE_EN
    logic [SAMPLE_W-PWM_BITS-1:0] err_r;
    logic [SAMPLE_W-PWM_BITS-1:0] conv_err_s;
`endif

    logic boundary_s;
    logic load_s;
    logic to_off_s;

    pwm_duty_conv #(
        .PWM_BITS (PWM_BITS)
    ) u_conv (
        .sample  (pend_r),
        .volume  (volume),
`ifdef AUDIO_PWM_NOISE_SHAPE_EN
        .err_in  (err_r),
        .err_out (conv_err_s),
`endif
        .duty    (conv_duty_s)
    );

    // Period boundary and the events that happen on it.
    always_comb begin
        boundary_s = 1'b0;
        load_s     = 1'b0;
        to_off_s   = 1'b0;
        boundary_s = (state_r != OFF) && (cnt_r == CNT_MAX);
        // WARM only hands over to RUN (and loads) on its last boundary while en holds.
        if (boundary_s) begin
            load_s   = (state_r == RUN) ||
                       ((state_r == WARM) && en && (warm_cnt_r == WARM_LAST));
            to_off_s = (state_r == STOP);
        end else begin
            load_s   = 1'b0;
            to_off_s = 1'b0;
        end
    end

    // Sequencer, period counter, active duty and registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= OFF;
            cnt_r      <= {PWM_BITS{1'b0}};
            warm_cnt_r <= {WARM_W{1'b0}};
            duty_r     <= {PWM_BITS{1'b0}};
            pwm_r      <= 1'b0;
            aud_sd_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            // STOP keeps playing the current duty until its boundary.
            pwm_r <= ((state_r == RUN) || (state_r == STOP)) && (cnt_r < duty_r);
            if (state_r == OFF) begin
                cnt_r <= {PWM_BITS{1'b0}};
            end else begin
                cnt_r <= cnt_r + PWM_BITS'(1'b1);
            end
            // No fresh sample at a loading boundary means the last duty repeats.
            if (load_s && pend_valid_r) begin
                duty_r <= conv_duty_s;
            end
            case (state_r)
                OFF: begin
                    if (en) begin
                        state_r    <= WARM;
                        aud_sd_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        warm_cnt_r <= {WARM_W{1'b0}};
                    end
                end
                WARM: begin
                    if (!en) begin
                        state_r <= STOP;
                    end else if (boundary_s) begin
                        if (warm_cnt_r == WARM_LAST) begin
                            state_r <= RUN;
                        end else begin
                            warm_cnt_r <= warm_cnt_r + WARM_W'(1'b1);
                        end
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_r <= STOP;
                    end
                end
                STOP: begin
                    if (boundary_s) begin
                        state_r    <= OFF;
                        aud_sd_r   <= 1'b0;
                        busy_r     <= 1'b0;
                        duty_r     <= {PWM_BITS{1'b0}};
                        warm_cnt_r <= {WARM_W{1'b0}};
                    end
                end
                default: begin
                    state_r  <= OFF;
                    aud_sd_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Pending sample buffer and saturating overrun counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r       <= {SAMPLE_W{1'b0}};
            pend_valid_r <= 1'b0;
            ovr_r        <= {OVR_BITS{1'b0}};
        end else begin
            if (to_off_s) begin
                pend_valid_r <= 1'b0;
            end else if (sample_valid) begin
                pend_r       <= sample_in;
                pend_valid_r <= 1'b1;
                // On a boundary the old value is consumed, so nothing is lost.
                if (pend_valid_r && !boundary_s && (ovr_r != OVR_MAX)) begin
                    ovr_r <= ovr_r + OVR_BITS'(1'b1);
                end
            end else if (load_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end
    end

`ifdef AUDIO_PWM_NOISE_SHAPE_EN
    // Truncation residue carried between consecutive conversions.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= {(SAMPLE_W - PWM_BITS){1'b0}};
        end else if (to_off_s) begin
            err_r <= {(SAMPLE_W - PWM_BITS){1'b0}};
        end else if (load_s && pend_valid_r) begin
            err_r <= conv_err_s;
        end else begin
            err_r <= err_r;
        end
    end
`endif

    assign pwm_out     = pwm_r;
    assign aud_sd      = aud_sd_r;
    assign busy        = busy_r;
    assign overrun_cnt = ovr_r;

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: self-checking bench for audio_pwm_out (PWM_BITS=8,
// WARMUP_PERIODS=16, OVR_BITS=8). Expectations come from period-level
// arithmetic: each PWM period's high-cycle count equals the duty derived
// from the sample consumed at the preceding boundary.
module tb_audio_pwm_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [3:0]  volume;
    logic        pwm_out;
    logic        aud_sd;
    logic        busy;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    int m_err    = 0;
    int stride   = 0;
    logic [15:0] stride_val = 16'h0000;
    int st_n = 0;
    int st_off [4];
    logic [15:0] st_val [4];

    always #5 clk = ~clk;

    audio_pwm_out #(
        .PWM_BITS       (8),
        .WARMUP_PERIODS (16),
        .OVR_BITS       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .volume       (volume),
        .pwm_out      (pwm_out),
        .aud_sd       (aud_sd),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt)
    );

    // Reference duty for one consumed sample: attenuate, then keep the top byte.
    function automatic int model_duty(input int x, input int vol);
        int a;
        int s;
        a = x / (1 << vol);
`ifdef AUDIO_PWM_NOISE_SHAPE_EN
        s = a + m_err;
        m_err = s % 256;
        if (s >= 65536) return 255;
        return s / 256;
`else
        s = a;
        return s / 256;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Run n cycles with the configured strobes; count pwm highs and amp-off cycles.
    task automatic run_ticks(input int n, output int highs, output int sd_low);
        highs  = 0;
        sd_low = 0;
        for (int i = 0; i < n; i++) begin
            int o;
            o = edge_n % 256;
            sample_valid = 1'b0;
            if (stride > 0 && (edge_n % stride) == 0) begin
                sample_valid = 1'b1;
                sample_in    = stride_val;
            end
            for (int j = 0; j < st_n; j++) begin
                if (st_off[j] == o) begin
                    sample_valid = 1'b1;
                    sample_in    = st_val[j];
                end
            end
            tick;
            highs  += int'(pwm_out);
            sd_low += int'(!aud_sd);
        end
        sample_valid = 1'b0;
    endtask

    // Reset, then raise en; edge_n counts edges since the enabling edge.
    task automatic start_play(input logic [3:0] vol);
        en = 1'b0; sample_valid = 1'b0; sample_in = 16'h0000; volume = vol;
        rst = 1'b1; tick; tick;
        rst = 1'b0; en = 1'b1; tick;
        edge_n = 0; m_err = 0; stride = 0; st_n = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; sample_valid = 1'b0; sample_in = 16'h0000; volume = 4'd0;
        tick; tick;
        rst = 1'b0; tick;
        sample_valid = 1'b1; sample_in = 16'h1234; tick;
        sample_in = 16'h5678; tick;
        sample_in = 16'h9ABC; tick;
        sample_valid = 1'b0;
        n_checks++;
        if (overrun_cnt !== 8'd2) $display("FAIL pre_reset_overrun: got %0d expected 2", overrun_cnt);
        else n_pass++;
        n_checks++;
        if ({aud_sd, busy} !== 2'b11) $display("FAIL pre_reset_on: got %b expected 11", {aud_sd, busy});
        else n_pass++;
        rst = 1'b1; tick;
        n_checks++;
        if ({pwm_out, aud_sd, busy} !== 3'b000) $display("FAIL reset_outputs: got %b expected 000", {pwm_out, aud_sd, busy});
        else n_pass++;
        n_checks++;
        if (overrun_cnt !== 8'd0) $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt);
        else n_pass++;
        rst = 1'b0; en = 1'b0; tick; tick;
        n_checks++;
        if ({aud_sd, busy} !== 2'b00) $display("FAIL reset_stays_off: got %b expected 00", {aud_sd, busy});
        else n_pass++;
    endtask

    task automatic test_stream_volume;
        int h;
        int sdl;
        int exp_h [6];
        int vols  [6];
        exp_h = '{128, 128, 128, 64, 64, 0};
        vols  = '{0, 0, 1, 1, 15, 15};
        start_play(4'd0);
        n_checks++;
        if ({aud_sd, busy} !== 2'b11) $display("FAIL amp_on_immediate: got %b expected 11", {aud_sd, busy});
        else n_pass++;
        stride = 202; stride_val = 16'h8000;
        run_ticks(4096, h, sdl);
        n_checks++;
        if (h !== 0) $display("FAIL warmup_silent: got %0d high cycles expected 0", h);
        else n_pass++;
        n_checks++;
        if (sdl !== 0) $display("FAIL warmup_amp_on: got %0d amp-off cycles expected 0", sdl);
        else n_pass++;
        for (int p = 0; p < 6; p++) begin
            volume = vols[p][3:0];
            run_ticks(256, h, sdl);
            n_checks++;
            if (h !== exp_h[p]) $display("FAIL stream_period%0d: got %0d high cycles expected %0d", p, h, exp_h[p]);
            else n_pass++;
        end
        stride = 0;
    endtask

    task automatic test_overrun;
        int h;
        int sdl;
        int e;
        start_play(4'd0);
        run_ticks(4096, h, sdl);
        st_n = 2;
        st_off[0] = 20;  st_val[0] = 16'h4000;
        st_off[1] = 100; st_val[1] = 16'hC000;
        run_ticks(256, h, sdl);
        st_n = 0;
        n_checks++;
        if (h !== 0) $display("FAIL overrun_first_period: got %0d expected 0", h);
        else n_pass++;
        n_checks++;
        if (overrun_cnt !== 8'd1) $display("FAIL overrun_one: got %0d expected 1", overrun_cnt);
        else n_pass++;
        e = model_duty(32'h0000C000, 0);
        run_ticks(256, h, sdl);
        n_checks++;
        if (h !== e) $display("FAIL overrun_newest_plays: got %0d expected %0d", h, e);
        else n_pass++;
        stride = 1; stride_val = 16'h1111;
        run_ticks(600, h, sdl);
        n_checks++;
        if (overrun_cnt !== 8'd255) $display("FAIL overrun_saturate: got %0d expected 255", overrun_cnt);
        else n_pass++;
        run_ticks(100, h, sdl);
        stride = 0;
        n_checks++;
        if (overrun_cnt !== 8'd255) $display("FAIL overrun_hold: got %0d expected 255", overrun_cnt);
        else n_pass++;
    endtask

    task automatic test_boundary_strobe;
        int h;
        int sdl;
        int e1;
        int e2;
        start_play(4'd0);
        run_ticks(4096, h, sdl);
        st_n = 2;
        st_off[0] = 100; st_val[0] = 16'h4000;
        st_off[1] = 255; st_val[1] = 16'hA000;
        run_ticks(256, h, sdl);
        st_n = 0;
        n_checks++;
        if (overrun_cnt !== 8'd0) $display("FAIL boundary_no_overrun: got %0d expected 0", overrun_cnt);
        else n_pass++;
        e1 = model_duty(32'h00004000, 0);
        e2 = model_duty(32'h0000A000, 0);
        run_ticks(256, h, sdl);
        n_checks++;
        if (h !== e1) $display("FAIL boundary_old_consumed: got %0d expected %0d", h, e1);
        else n_pass++;
        run_ticks(256, h, sdl);
        n_checks++;
        if (h !== e2) $display("FAIL boundary_new_plays: got %0d expected %0d", h, e2);
        else n_pass++;
        run_ticks(256, h, sdl);
        n_checks++;
        if (h !== e2) $display("FAIL boundary_repeat: got %0d expected %0d", h, e2);
        else n_pass++;
    endtask

    task automatic test_random;
        int h;
        int sdl;
        int exp_h;
        int exp_ovr;
        int k;
        int vol;
        start_play(4'($urandom_range(0, 15)));
        run_ticks(4096, h, sdl);
        exp_h = 0;
        exp_ovr = 0;
        for (int p = 0; p < 10; p++) begin
            vol = int'($urandom_range(0, 9));
            volume = vol[3:0];
            k = int'($urandom_range(1, 4));
            st_n = k;
            for (int j = 0; j < k; j++) begin
                st_off[j] = j * 60 + int'($urandom_range(0, 50));
                st_val[j] = 16'($urandom);
            end
            run_ticks(256, h, sdl);
            n_checks++;
            if (h !== exp_h) $display("FAIL random_period%0d: got %0d expected %0d", p, h, exp_h);
            else n_pass++;
            exp_ovr = (exp_ovr + k - 1 > 255) ? 255 : exp_ovr + k - 1;
            n_checks++;
            if (int'(overrun_cnt) !== exp_ovr) $display("FAIL random_overrun%0d: got %0d expected %0d", p, overrun_cnt, exp_ovr);
            else n_pass++;
            exp_h = model_duty(int'(st_val[k-1]), vol);
        end
        st_n = 0;
    endtask

    task automatic test_stop;
        int h;
        int sdl;
        start_play(4'd0);
        st_n = 1; st_off[0] = 100; st_val[0] = 16'h8000;
        run_ticks(4096, h, sdl);
        st_n = 0;
        run_ticks(256, h, sdl);
        n_checks++;
        if (h !== 128) $display("FAIL stop_pre_period: got %0d expected 128", h);
        else n_pass++;
        h = 0;
        for (int o = 0; o < 256; o++) begin
            en = (o < 10) || (o >= 50 && o < 60);
            tick;
            h += int'(pwm_out);
            if (o == 60) begin
                n_checks++;
                if ({aud_sd, busy} !== 2'b11) $display("FAIL stop_still_on: got %b expected 11", {aud_sd, busy});
                else n_pass++;
            end
        end
        n_checks++;
        if (h !== 128) $display("FAIL stop_period_completes: got %0d expected 128", h);
        else n_pass++;
        n_checks++;
        if ({pwm_out, aud_sd, busy} !== 3'b000) $display("FAIL stop_to_off: got %b expected 000", {pwm_out, aud_sd, busy});
        else n_pass++;
        h = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            h += int'(pwm_out) + int'(busy) + int'(aud_sd);
        end
        n_checks++;
        if (h !== 0) $display("FAIL off_stays_quiet: got %0d active cycles expected 0", h);
        else n_pass++;
    endtask

    task automatic test_noise_pattern;
        int h;
        int sdl;
        int e;
        start_play(4'd0);
        run_ticks(4096, h, sdl);
        e = 0;
        st_n = 1; st_off[0] = 100; st_val[0] = 16'h0080;
        for (int p = 0; p < 5; p++) begin
            run_ticks(256, h, sdl);
            n_checks++;
            if (h !== e) $display("FAIL noise_period%0d: got %0d expected %0d", p, h, e);
            else n_pass++;
            e = model_duty(32'h00000080, 0);
        end
        st_n = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_in = 16'h0000; volume = 4'd0;
        test_reset;
        test_stream_volume;
        test_overrun;
        test_boundary_strobe;
        test_random;
        test_stop;
        test_noise_pattern;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
